config_loader: RTL
==================

// Module: config_loader
// PURPOSE
//  Upstream feeder for the configuration shift register (NWEIGHTS-bit scan chain).
//  Accepts configuration words over a valid/ready interface and serialises them MSB-first onto the chain's configIn.
//  Produces a per-cycle shift enable that drives the chain's clock gate.
//  Signals done after exactly NWEIGHTS bits have been shifted.
// PARAMETERS
//  NWEIGHTS  5775  chain length in bits; must match the downstream register
//  WORD_W    32    input word width; 1 <= WORD_W <= NWEIGHTS
// PORTS
//  configClk     in   1                    single clock; posedge
//  configRst     in   1                    reset, asynchronous, active-low
//  start         in   1                    pulse: begin a load (honoured in IDLE only)
//  abort         in   1                    pulse: cancel the load in progress
//  word_valid    in   1                    word_data is valid
//  word_data     in   WORD_W               configuration word
//  word_ready    out  1                    loader accepts word_data this cycle
//  configSerOut  out  1                    serial bit, wired to the chain's configIn
//  configShiftEn out  1                    chain shifts on the edge ending this cycle (drives the ICG)
//  configRetIn   in   1                    chain configOut (used only with CONFIG_READBACK_EN)
//  busy          out  1                    high in LOAD/SHIFT
//  done          out  1                    one-cycle pulse: NWEIGHTS bits shifted
//  readback_crc  out  16                   CRC of displaced chain contents (feature only)
// BEHAVIOUR
//  Reset values: word_ready=0, configSerOut=0, configShiftEn=0, busy=0, done=0, readback_crc=16'hFFFF.
//  All internal counters and registers reset to 0; the state resets to IDLE.
//  Word framing: NWORDS = ceil(NWEIGHTS/WORD_W); REM = NWEIGHTS - (NWORDS-1)*WORD_W.
//   Word 0 carries chain bits [NWEIGHTS-1 -: REM] in word_data[REM-1:0]; its upper bits are ignored.
//   Words 1..NWORDS-1 are full words, sent bit WORD_W-1 first.
//   Chain bit 0 is therefore the last bit shifted.
//  States:
//   IDLE : start moves to LOAD (busy=1).
//   LOAD : word_ready=1; word_valid&&word_ready latches the word and moves to SHIFT.
//   SHIFT: each cycle drives one bit with configShiftEn=1.
//          On the last bit of a word, word_ready=1, so a word presented then is accepted with no gap cycle.
//          If no word is present, go to LOAD with configShiftEn=0; the chain holds.
//   DONE : reached when the total bit count equals NWEIGHTS. done=1 for one cycle, then IDLE.
//          Extra words are never accepted.
//  Latency: word accepted at edge k; its first bit is valid with configShiftEn=1 during cycle k+1.
//  Minimum load time is NWEIGHTS+1 cycles from the first acceptance to done.
//  configSerOut and configShiftEn are registered outputs, so there are no glitches on the clock-gate enable.
//  Counters: bit_idx is clog2(WORD_W) bits; bit_cnt is clog2(NWEIGHTS+1) bits. Neither wraps: bit_cnt saturates at NWEIGHTS.
//  start while busy: ignored.
//  abort: takes effect on the next edge. State goes to IDLE; configShiftEn, word_ready and busy go to 0; no done pulse.
//   The chain holds partial data. A word accepted in the same cycle is discarded.
//  abort and start in the same cycle: abort wins.
//  Reset mid-load: immediate return to reset values; the chain contents are undefined to the loader.
//  WORD_W == NWEIGHTS: NWORDS=1 and REM=NWEIGHTS.
// CONFIGURATION
//  CONFIG_READBACK_EN defined:
//   configRetIn is sampled on every cycle with configShiftEn=1.
//   The sampled bits (the previous chain contents) feed a CRC-16/CCITT (poly 0x1021, init 0xFFFF, MSB-first).
//   The CRC is re-initialised on start; readback_crc is stable from done until the next start.
//  CONFIG_READBACK_EN undefined:
//   No CRC logic; configRetIn is unused and readback_crc is tied to 16'hFFFF.
// STRUCTURE
//  Package config_loader_pkg: state enum (IDLE/LOAD/SHIFT/DONE); localparam functions for NWORDS, REM and counter widths; CRC16_POLY and CRC16_INIT.
//  Sub-module config_crc16: 1-bit serial CRC with init/enable inputs; instantiated only under CONFIG_READBACK_EN.
// TESTING (bench instantiates the loader and the NWEIGHTS shift register together; NWEIGHTS=40, WORD_W=16 unless stated)
//  Streaming load:
//   Stimulus: start, then 3 back-to-back words 0x00AB, 0x1234, 0x5678 (REM=8).
//   Required: parallelOut=40'hAB_1234_5678; configShiftEn high for exactly 40 cycles; done on cycle 42.
//  Stalled word:
//   Stimulus: withhold word_valid for 5 cycles after the second word.
//   Required: configShiftEn low for those cycles; same final parallelOut; done 5 cycles later.
//  Abort at bit 20:
//   Required: busy drops next edge; no done pulse.
//   Then a new start with all-ones words gives parallelOut=40'hFF_FFFF_FFFF.
//  Async reset:
//   Stimulus: assert configRst mid-SHIFT.
//   Required: outputs reach reset values without a clock edge; start is ignored while busy in a fresh load.
//  Defaults (NWEIGHTS=5775, WORD_W=32):
//   Stimulus: 181 words, word 0 = 0x7FFF, others 0.
//   Required: only bits [5774:5760] set; done after 5775 shifts.
//  With CONFIG_READBACK_EN:
//   Stimulus: load pattern A, then load pattern B.
//   Required: readback_crc after the second load equals the model CRC-16 of A's bits in shift order.

Source files
------------

// File: rtl/config_loader_pkg.sv
// config_loader_pkg: state encoding, word-framing helpers and CRC-16 constants
// shared by config_loader and config_crc16.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } loaderState_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic int nWordsOf(input int nWeights, input int wordW);
    return (nWeights + wordW - 1) / wordW;
  endfunction

  // Width of word 0, which carries the top (most significant) chain bits.
  function automatic int remOf(input int nWeights, input int wordW);
    return nWeights - (nWordsOf(nWeights, wordW) - 1) * wordW;
  endfunction

  function automatic int widthOf(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/config_crc16.sv
// config_crc16: bit-serial CRC-16/CCITT (MSB-first) with synchronous init and
// per-bit enable; used to fingerprint the chain contents displaced by a load.
module config_crc16
  import config_loader_pkg::*;
(
  input  logic        configClk,
  input  logic        configRst,
  input  logic        init,
  input  logic        en,
  input  logic        dataIn,
  output logic [15:0] crc
);

  logic feedback;

  assign feedback = crc[15] ^ dataIn;

  always_ff @(posedge configClk or negedge configRst) begin
    if (!configRst) begin
      crc <= CRC16_INIT;
    end else if (init) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/config_loader.sv
// config_loader: accepts configuration words and streams them MSB-first into the
// NWEIGHTS-bit scan chain. Define CONFIG_READBACK_EN for CRC readback of old contents.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int NWEIGHTS = 5775,
  parameter int WORD_W   = 32
) (
  input  logic              configClk,
  input  logic              configRst,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              configSerOut,
  output logic              configShiftEn,
  input  logic              configRetIn,
  output logic              busy,
  output logic              done,
  output logic [15:0]       readback_crc
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | word_ready high, waiting for the next word
  // SHIFT | one bit per cycle onto the chain
  // DONE  | all NWEIGHTS bits shifted, done pulse

  localparam int REM   = remOf(NWEIGHTS, WORD_W);
  localparam int IDX_W = widthOf(WORD_W);
  localparam int CNT_W = widthOf(NWEIGHTS + 1);
  localparam int ALIGN = WORD_W - REM;

  localparam logic [IDX_W-1:0] LAST_FULL_IDX = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] LAST_REM_IDX  = IDX_W'(REM - 1);
  localparam logic [CNT_W-1:0] TOTAL_BITS    = CNT_W'(NWEIGHTS);

  loaderState_t      state;
  logic [WORD_W-1:0] shiftReg;
  logic [IDX_W-1:0]  bitIdx;
  logic [CNT_W-1:0]  bitCnt;
  logic [CNT_W-1:0]  bitCntNext;
  logic [WORD_W-1:0] alignedWord;
  logic              wordEnd;
  logic              chainFull;
  logic              accept;

  // bitIdx counts the bits still to come in the current word after the one on the wire.
  assign wordEnd    = (bitIdx == '0);
  assign chainFull  = (bitCnt == TOTAL_BITS);
  assign bitCntNext = chainFull ? bitCnt : bitCnt + 1'b1;

  assign word_ready = (state == LOAD) || ((state == SHIFT) && wordEnd && !chainFull);
  assign accept     = word_valid && word_ready;
  assign busy       = (state == LOAD) || (state == SHIFT);
  assign done       = (state == DONE);

  // Word 0 is short; left-justify it so every word leaves from the MSB.
  assign alignedWord = (bitCnt == '0) ? (word_data << ALIGN) : word_data;

  always_ff @(posedge configClk or negedge configRst) begin
    if (!configRst) begin
      state         <= IDLE;
      shiftReg      <= '0;
      bitIdx        <= '0;
      bitCnt        <= '0;
      configSerOut  <= 1'b0;
      configShiftEn <= 1'b0;
    end else if (abort) begin
      state         <= IDLE;
      configShiftEn <= 1'b0;
    end else begin
      configShiftEn <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            bitCnt <= '0;
          end
        end
        LOAD, SHIFT: begin
          if ((state == SHIFT) && !wordEnd) begin
            configSerOut  <= shiftReg[WORD_W-1];
            shiftReg      <= shiftReg << 1;
            bitIdx        <= bitIdx - 1'b1;
            bitCnt        <= bitCntNext;
            configShiftEn <= 1'b1;
          end else if (accept) begin
            configSerOut  <= alignedWord[WORD_W-1];
            shiftReg      <= alignedWord << 1;
            bitIdx        <= (bitCnt == '0) ? LAST_REM_IDX : LAST_FULL_IDX;
            bitCnt        <= bitCntNext;
            configShiftEn <= 1'b1;
            state         <= SHIFT;
          end else if ((state == SHIFT) && chainFull) begin
            state <= DONE;
          end else begin
            state <= LOAD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONFIG_READBACK_EN
  logic crcInit;

  assign crcInit = start && !abort && (state == IDLE);

  config_crc16 uCrc (
    .configClk (configClk),
    .configRst (configRst),
    .init      (crcInit),
    .en        (configShiftEn),
    .dataIn    (configRetIn),
    .crc       (readback_crc)
  );
`else
  logic unusedRetIn;

  assign unusedRetIn  = configRetIn;
  assign readback_crc = CRC16_INIT;
`endif

endmodule
